cvxif_copro_responder: RTL and testbench
========================================

Name: cvxif_copro_responder

Overview:
- Coprocessor-side responder for the CoreV-X-Interface. It is the far end of the offload path whose initiator is the core's execute stage.
- Accepts offloaded custom-0 instructions, reports accept/writeback in the same cycle, and buffers accepted instructions until the core commits or kills them.
- Committed instructions execute with fixed latency; results return to the core through a valid/ready result channel.

Parameters:
- XLEN, 64, operand/result width.
- ID_WIDTH, 4, offload transaction id width; must equal TRANS_ID_BITS.
- DEPTH, 4, entries in the pending-instruction FIFO; power of two, at least 2.
- LATENCY, 2, execute cycles from commit-head start to result valid; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- x_issue_valid_i  in  1  issue request valid.
- x_issue_ready_o  out  1  issue request accepted this cycle.
- x_issue_instr_i  in  32  offloaded instruction.
- x_issue_rs1_i  in  XLEN  rs1 operand.
- x_issue_rs2_i  in  XLEN  rs2 operand.
- x_issue_id_i  in  ID_WIDTH  transaction id.
- x_issue_accept_o  out  1  instruction recognised by the coprocessor.
- x_issue_writeback_o  out  1  instruction will write rd.
- x_commit_valid_i  in  1  commit/kill strobe.
- x_commit_id_i  in  ID_WIDTH  id being committed.
- x_commit_kill_i  in  1  1 = discard, 0 = execute.
- x_result_valid_o  out  1  result valid.
- x_result_ready_i  in  1  core takes result.
- x_result_id_o  out  ID_WIDTH  result id.
- x_result_data_o  out  XLEN  result data.
- x_result_rd_o  out  5  destination register.
- x_result_we_o  out  1  write enable.
- x_result_exc_o  out  1  exception flag.
- x_result_exccode_o  out  6  exception cause.

Behaviour:
- Reset (rst_i high at a clock edge): FIFO empty, FSM IDLE, counter 0. All outputs 0, except x_issue_ready_o, which is 1.
- Reset mid-operation drops all pending and executing entries with no result emitted.

Decode is combinational on x_issue_instr_i:
- Recognised means opcode 7'b0001011 and funct7 = 0.
- funct3 000 ADD rs1+rs2; 001 SUB rs1-rs2; 010 XOR; 011 AND; 100 OR; 101 SLL rs1<<rs2[5:0]; 110 NOP (no writeback).
- Arithmetic wraps modulo 2^XLEN.
- x_issue_accept_o = recognised. x_issue_writeback_o = recognised && funct3 != 110.

Issue handshake:
- x_issue_ready_o = !fifo_full.
- A transfer occurs when valid && ready.
- Only accepted transfers push an entry: {id, op, rs1, rs2, rd, we, committed=0, killed=0}.
- Rejected transfers complete the handshake with accept=0 and push nothing.

Commit:
- A commit strobe searches all valid entries for a matching id and sets committed, or killed when x_commit_kill_i=1.
- A strobe for an absent id is ignored.
- A same-cycle push and commit of the same id marks the new entry.

FSM:
- IDLE: head valid && killed → pop, stay IDLE. Head valid && committed && !killed → EXEC, counter = LATENCY-1.
- EXEC: counter decrements; at 0, latch the result and go to RESP.
- RESP: x_result_valid_o=1 and the result fields are held stable until x_result_ready_i. On the handshake, pop and return to IDLE; the next head is evaluated the following cycle.
- NOP results return with we=0 and data 0.
- Results are returned in issue order.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle; no same-cycle pop-push bypass.
- Pointers wrap modulo DEPTH; full/empty are derived from an extra pointer bit.

Optional Feature:
CVXIF_COPRO_EXC_EN
- Defined: funct3 111 is recognised (accept=1, writeback=0). It queues and commits normally, then returns in RESP with x_result_exc_o=1, x_result_exccode_o=2 (illegal instruction), we=0, data 0.
- Undefined: funct3 111 is unrecognised (accept=0). x_result_exc_o and x_result_exccode_o are tied to 0.

Decomposition:
- cvxif_copro_pkg holds:
  - opcode constant CUSTOM0_OPCODE;
  - enum copro_op_e (ADD, SUB, XOR, AND, OR, SLL, NOP, EXC);
  - struct copro_entry_t;
  - enum copro_state_e (IDLE, EXEC, RESP).
- One sub-module, cvxif_copro_decoder: combinational instr → {recognised, op, we, rd}.

Test Plan:
- Issue ADD id=3, rs1=5, rs2=7, rd=10; commit id=3, kill=0 → accept=1, writeback=1. Exactly LATENCY+1 cycles after commit, result valid with id=3, data 12, rd 10, we 1, held until ready.
- Issue opcode 0110011 → ready=1 and accept=0 in the same cycle; FIFO count unchanged; no result ever.
- Issue ids 1, 2, 3; commit 1, kill 2, commit 3 → results id1 then id3; id2 is never emitted.
- Issue DEPTH=4 instructions without committing → ready drops to 0 after the 4th. Commit the head and take its result → ready returns to 1 the cycle after the pop.
- Hold result ready=0 for 5 cycles with SUB rs1=0, rs2=1 → data stays 0xFFFF_FFFF_FFFF_FFFF and stable. Assert rst_i mid-EXEC → valid=0 and ready=1 next cycle.
- CVXIF_COPRO_EXC_EN defined, funct3=111 issued and committed → exc=1, exccode=2, we=0. With the macro undefined → accept=0.

Source files
------------

// File: rtl/cvxif_copro_pkg.sv
// ---------------------------------------------------------------------------
// cvxif_copro_pkg
// Shared types and constants for the CoreV-X-Interface coprocessor responder:
//   - CUSTOM0_OPCODE : major opcode of the offloaded custom-0 instructions
//   - TRANS_ID_BITS  : offload transaction id width (ID_WIDTH must match)
//   - copro_op_e     : operation encoded in funct3
//   - copro_entry_t  : control fields of one pending-instruction FIFO entry
//   - copro_state_e  : execute/response FSM states
// ---------------------------------------------------------------------------
package cvxif_copro_pkg;

  localparam logic [6:0] CUSTOM0_OPCODE  = 7'b0001011;
  localparam int unsigned TRANS_ID_BITS  = 4;
  localparam logic [5:0] EXCCODE_ILLEGAL = 6'd2;

  // Encoding equals funct3, so the decoder can cast the field directly.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_SLL = 3'b101,
    OP_NOP = 3'b110,
    OP_EXC = 3'b111
  } copro_op_e;

  // Operands are kept in separate XLEN-wide arrays next to this struct so the
  // operand width stays a parameter of the responder.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    copro_op_e                op;
    logic [4:0]               rd;
    logic                     we;
    logic                     committed;
    logic                     killed;
  } copro_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } copro_state_e;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// ---------------------------------------------------------------------------
// cvxif_copro_decoder
// Combinational decode of an offloaded instruction.
//   instr_i      : 32-bit instruction word
//   recognised_o : custom-0 opcode, funct7 == 0, supported funct3
//   op_o         : operation (funct3)
//   we_o         : instruction writes rd
//   rd_o         : destination register field
// Optional macro CVXIF_COPRO_EXC_EN: when defined, funct3 111 is recognised
// as an instruction that returns an illegal-instruction exception.
// ---------------------------------------------------------------------------
module cvxif_copro_decoder
  import cvxif_copro_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        recognised_o,
  output copro_op_e   op_o,
  output logic        we_o,
  output logic [4:0]  rd_o
);

  // Register-source fields travel as operands, not as indices.
  logic unused_src_fields;
  assign unused_src_fields = ^instr_i[24:15];

  // NOTE: every output gets a value before any condition, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    op_o         = copro_op_e'(instr_i[14:12]);
    rd_o         = instr_i[11:7];
    recognised_o = (instr_i[6:0] == CUSTOM0_OPCODE) && (instr_i[31:25] == 7'd0);
`ifndef CVXIF_COPRO_EXC_EN
    if (instr_i[14:12] == 3'b111) begin
      recognised_o = 1'b0;
    end
`endif
    we_o = recognised_o && (op_o != OP_NOP) && (op_o != OP_EXC);
  end

endmodule

// File: rtl/cvxif_copro_responder.sv
// ---------------------------------------------------------------------------
// cvxif_copro_responder
// Coprocessor end of the CoreV-X-Interface offload path. Accepted custom-0
// instructions are queued in issue order; commit/kill strobes mark them; the
// head executes with fixed latency once committed and its result is offered
// on a valid/ready channel. Killed heads are dropped silently.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   x_issue_*                   : issue request/response (accept, writeback)
//   x_commit_*                  : commit (kill=0) or discard (kill=1) by id
//   x_result_*                  : result channel, held stable until ready
// Optional macro CVXIF_COPRO_EXC_EN: funct3 111 returns an illegal-instruction
// exception; otherwise x_result_exc_o/x_result_exccode_o are tied to 0.
// ---------------------------------------------------------------------------
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ID_WIDTH = TRANS_ID_BITS,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                x_issue_valid_i,
  output logic                x_issue_ready_o,
  input  logic [31:0]         x_issue_instr_i,
  input  logic [XLEN-1:0]     x_issue_rs1_i,
  input  logic [XLEN-1:0]     x_issue_rs2_i,
  input  logic [ID_WIDTH-1:0] x_issue_id_i,
  output logic                x_issue_accept_o,
  output logic                x_issue_writeback_o,
  input  logic                x_commit_valid_i,
  input  logic [ID_WIDTH-1:0] x_commit_id_i,
  input  logic                x_commit_kill_i,
  output logic                x_result_valid_o,
  input  logic                x_result_ready_i,
  output logic [ID_WIDTH-1:0] x_result_id_o,
  output logic [XLEN-1:0]     x_result_data_o,
  output logic [4:0]          x_result_rd_o,
  output logic                x_result_we_o,
  output logic                x_result_exc_o,
  output logic [5:0]          x_result_exccode_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic      dec_recognised;
  copro_op_e dec_op;
  logic      dec_we;
  logic [4:0] dec_rd;

  cvxif_copro_decoder u_decoder (
    .instr_i      (x_issue_instr_i),
    .recognised_o (dec_recognised),
    .op_o         (dec_op),
    .we_o         (dec_we),
    .rd_o         (dec_rd)
  );

  // -------------------------------------------------------------------------
  // Pending-instruction FIFO (extra pointer bit distinguishes full from empty)
  // -------------------------------------------------------------------------
  copro_entry_t          mem_ctrl_q [DEPTH];
  logic [XLEN-1:0]       mem_rs1_q  [DEPTH];
  logic [XLEN-1:0]       mem_rs2_q  [DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q, fifo_count;
  logic [PTR_W-1:0]      wr_idx, rd_idx;
  logic                  fifo_full, fifo_empty;
  logic [DEPTH-1:0]      slot_valid;
  logic                  push, pop;
  logic                  commit_hits_new;

  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);

  // Ready depends only on registered state: a pop never frees a slot for a
  // push in the same cycle.
  assign x_issue_ready_o     = !fifo_full;
  assign x_issue_accept_o    = dec_recognised;
  assign x_issue_writeback_o = dec_we;

  // Rejected instructions complete the handshake but never occupy a slot.
  assign push            = x_issue_valid_i && x_issue_ready_o && dec_recognised;
  assign commit_hits_new = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, (PTR_W'(i) - rd_idx)} < fifo_count);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: the entry storage has no reset; the pointers define which slots are
  // live, so stale contents after reset are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ctrl_q[wr_idx] <= '{
        id:        x_issue_id_i,
        op:        dec_op,
        rd:        dec_rd,
        we:        dec_we,
        committed: commit_hits_new && !x_commit_kill_i,
        killed:    commit_hits_new && x_commit_kill_i
      };
      mem_rs1_q[wr_idx] <= x_issue_rs1_i;
      mem_rs2_q[wr_idx] <= x_issue_rs2_i;
    end
    // The slot being pushed is never live, so these marks cannot collide
    // with the write above.
    if (x_commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[i] && (mem_ctrl_q[i].id == x_commit_id_i)) begin
          if (x_commit_kill_i) mem_ctrl_q[i].killed    <= 1'b1;
          else                 mem_ctrl_q[i].committed <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Execute unit (operates on the FIFO head)
  // -------------------------------------------------------------------------
  copro_entry_t    head;
  logic [XLEN-1:0] head_rs1, head_rs2, exec_data;

  assign head     = mem_ctrl_q[rd_idx];
  assign head_rs1 = mem_rs1_q[rd_idx];
  assign head_rs2 = mem_rs2_q[rd_idx];

  always_comb begin
    exec_data = '0;
    unique case (head.op)
      OP_ADD:  exec_data = head_rs1 + head_rs2;
      OP_SUB:  exec_data = head_rs1 - head_rs2;
      OP_XOR:  exec_data = head_rs1 ^ head_rs2;
      OP_AND:  exec_data = head_rs1 & head_rs2;
      OP_OR:   exec_data = head_rs1 | head_rs2;
      OP_SLL:  exec_data = head_rs1 << head_rs2[SHAMT_W-1:0];
      default: exec_data = '0;  // NOP and EXC return zero data
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  copro_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_result;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    latch_result = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && head.killed) begin
          pop = 1'b1;
        end else if (!fifo_empty && head.committed) begin
          state_d = EXEC;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          latch_result = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (x_result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Result registers (stable for the whole RESP phase)
  // -------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] res_id_q;
  logic [XLEN-1:0]     res_data_q;
  logic [4:0]          res_rd_q;
  logic                res_we_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_id_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
    end else if (latch_result) begin
      res_id_q   <= head.id;
      res_data_q <= exec_data;
      res_rd_q   <= head.rd;
      res_we_q   <= head.we;
    end
  end

  assign x_result_valid_o = (state_q == RESP);
  assign x_result_id_o    = res_id_q;
  assign x_result_data_o  = res_data_q;
  assign x_result_rd_o    = res_rd_q;
  assign x_result_we_o    = res_we_q;

`ifdef CVXIF_COPRO_EXC_EN
  logic       res_exc_q;
  logic [5:0] res_exccode_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_exc_q     <= 1'b0;
      res_exccode_q <= '0;
    end else if (latch_result) begin
      res_exc_q     <= (head.op == OP_EXC);
      res_exccode_q <= (head.op == OP_EXC) ? EXCCODE_ILLEGAL : 6'd0;
    end
  end

  assign x_result_exc_o     = res_exc_q;
  assign x_result_exccode_o = res_exccode_q;
`else
  assign x_result_exc_o     = 1'b0;
  assign x_result_exccode_o = 6'd0;
`endif

endmodule

// File: tb/tb_cvxif_copro_responder.sv
`timescale 1ns/1ps
module tb_cvxif_copro_responder;

  localparam int XLEN = 64, ID_WIDTH = 4, DEPTH = 4, LATENCY = 2;
  localparam logic [6:0] C0 = 7'b0001011;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                x_issue_valid_i, x_issue_ready_o;
  logic [31:0]         x_issue_instr_i;
  logic [XLEN-1:0]     x_issue_rs1_i, x_issue_rs2_i;
  logic [ID_WIDTH-1:0] x_issue_id_i;
  logic                x_issue_accept_o, x_issue_writeback_o;
  logic                x_commit_valid_i, x_commit_kill_i;
  logic [ID_WIDTH-1:0] x_commit_id_i;
  logic                x_result_valid_o, x_result_ready_i;
  logic [ID_WIDTH-1:0] x_result_id_o;
  logic [XLEN-1:0]     x_result_data_o;
  logic [4:0]          x_result_rd_o;
  logic                x_result_we_o, x_result_exc_o;
  logic [5:0]          x_result_exccode_o;

  always #5 clk_i = ~clk_i;

  cvxif_copro_responder #(
    .XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_issue_valid_i     (x_issue_valid_i),
    .x_issue_ready_o     (x_issue_ready_o),
    .x_issue_instr_i     (x_issue_instr_i),
    .x_issue_rs1_i       (x_issue_rs1_i),
    .x_issue_rs2_i       (x_issue_rs2_i),
    .x_issue_id_i        (x_issue_id_i),
    .x_issue_accept_o    (x_issue_accept_o),
    .x_issue_writeback_o (x_issue_writeback_o),
    .x_commit_valid_i    (x_commit_valid_i),
    .x_commit_id_i       (x_commit_id_i),
    .x_commit_kill_i     (x_commit_kill_i),
    .x_result_valid_o    (x_result_valid_o),
    .x_result_ready_i    (x_result_ready_i),
    .x_result_id_o       (x_result_id_o),
    .x_result_data_o     (x_result_data_o),
    .x_result_rd_o       (x_result_rd_o),
    .x_result_we_o       (x_result_we_o),
    .x_result_exc_o      (x_result_exc_o),
    .x_result_exccode_o  (x_result_exccode_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic issue(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] id, output logic acc, output logic wb, output logic rdy);
    x_issue_valid_i = 1'b1;
    x_issue_instr_i = instr;
    x_issue_rs1_i   = a;
    x_issue_rs2_i   = b;
    x_issue_id_i    = id;
    #1;
    acc = x_issue_accept_o;
    wb  = x_issue_writeback_o;
    rdy = x_issue_ready_o;
    @(posedge clk_i);
    @(negedge clk_i);
    x_issue_valid_i = 1'b0;
    x_issue_instr_i = '0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = id;
    x_commit_kill_i  = kill;
    @(posedge clk_i);
    @(negedge clk_i);
    x_commit_valid_i = 1'b0;
    x_commit_kill_i  = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!x_result_valid_o && cyc < 40) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic take_result();
    x_result_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    x_result_ready_i = 1'b0;
  endtask

  task automatic expect_no_result(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (x_result_valid_o) seen = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check(name, seen, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] rs1, rs2;
    logic [3:0]  id;
    logic        acc, wb;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic [5:0]  code;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic acc, wb, rdy;
    int   cyc;

    vecs[0] = '{"add",      mk_instr(7'd0, 3'b000, 5'd10, C0), 64'd5, 64'd7, 4'd3, 1'b1, 1'b1, 64'd12, 5'd10, 1'b0, 6'd0};
    vecs[1] = '{"sub",      mk_instr(7'd0, 3'b001, 5'd1,  C0), 64'd0, 64'd1, 4'd4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0, 6'd0};
    vecs[2] = '{"xor",      mk_instr(7'd0, 3'b010, 5'd2,  C0), 64'h00FF_00FF_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 4'd5, 1'b1, 1'b1, 64'h0FF0_0FF0_EDCB_5678, 5'd2, 1'b0, 6'd0};
    vecs[3] = '{"and",      mk_instr(7'd0, 3'b011, 5'd3,  C0), 64'h00FF_00FF_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 4'd6, 1'b1, 1'b1, 64'h000F_000F_1234_0000, 5'd3, 1'b0, 6'd0};
    vecs[4] = '{"or",       mk_instr(7'd0, 3'b100, 5'd4,  C0), 64'h00FF_00FF_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 4'd7, 1'b1, 1'b1, 64'h0FFF_0FFF_FFFF_5678, 5'd4, 1'b0, 6'd0};
    vecs[5] = '{"add_wrap", mk_instr(7'd0, 3'b000, 5'd5,  C0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd8, 1'b1, 1'b1, 64'd1, 5'd5, 1'b0, 6'd0};
    vecs[6] = '{"sll63",    mk_instr(7'd0, 3'b101, 5'd6,  C0), 64'd1, 64'd63, 4'd9, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 5'd6, 1'b0, 6'd0};
    vecs[7] = '{"sll_mask", mk_instr(7'd0, 3'b101, 5'd8,  C0), 64'd3, 64'h41, 4'd10, 1'b1, 1'b1, 64'd6, 5'd8, 1'b0, 6'd0};
    vecs[8] = '{"nop",      mk_instr(7'd0, 3'b110, 5'd9,  C0), 64'd5, 64'd5, 4'd11, 1'b1, 1'b0, 64'd0, 5'd9, 1'b0, 6'd0};
    vecs[9] = '{"bad_f7",   mk_instr(7'd1, 3'b000, 5'd11, C0), 64'd1, 64'd1, 4'd12, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 6'd0};
`ifdef CVXIF_COPRO_EXC_EN
    vecs[10] = '{"exc111",  mk_instr(7'd0, 3'b111, 5'd7,  C0), 64'd1, 64'd2, 4'd15, 1'b1, 1'b0, 64'd0, 5'd7, 1'b1, 6'd2};
`else
    vecs[10] = '{"rej111",  mk_instr(7'd0, 3'b111, 5'd7,  C0), 64'd1, 64'd2, 4'd15, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 6'd0};
`endif

    rst_i = 1'b1;
    x_issue_valid_i = 1'b0; x_issue_instr_i = '0; x_issue_rs1_i = '0; x_issue_rs2_i = '0;
    x_issue_id_i = '0; x_commit_valid_i = 1'b0; x_commit_id_i = '0; x_commit_kill_i = 1'b0;
    x_result_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    // Reset state
    check("rst_valid",   x_result_valid_o, 1'b0);
    check("rst_ready",   x_issue_ready_o, 1'b1);
    check("rst_accept",  x_issue_accept_o, 1'b0);
    check("rst_id",      x_result_id_o, 4'd0);
    check("rst_data",    x_result_data_o, 64'd0);
    check("rst_rd_we",   {x_result_rd_o, x_result_we_o}, 6'd0);
    check("rst_exc",     {x_result_exc_o, x_result_exccode_o}, 7'd0);
    rst_i = 1'b0;

    // Rejected non-custom opcode: handshake completes, nothing queued
    issue(32'h0020_80B3, 64'd1, 64'd2, 4'd2, acc, wb, rdy);
    check("alu_op_ready",  rdy, 1'b1);
    check("alu_op_accept", acc, 1'b0);
    check("alu_op_wb",     wb, 1'b0);
    commit(4'd2, 1'b0);
    expect_no_result("alu_op_no_result", 8);

    // Single-instruction table
    for (int v = 0; v < 11; v++) begin
      issue(vecs[v].instr, vecs[v].rs1, vecs[v].rs2, vecs[v].id, acc, wb, rdy);
      check({vecs[v].name, "_ready"},  rdy, 1'b1);
      check({vecs[v].name, "_accept"}, acc, vecs[v].acc);
      check({vecs[v].name, "_wb"},     wb,  vecs[v].wb);
      if (vecs[v].acc) begin
        commit(vecs[v].id, 1'b0);
        wait_result(cyc);
        check({vecs[v].name, "_valid"},   x_result_valid_o, 1'b1);
        check({vecs[v].name, "_latency"}, cyc, LATENCY + 1);
        check({vecs[v].name, "_id"},      x_result_id_o, vecs[v].id);
        check({vecs[v].name, "_data"},    x_result_data_o, vecs[v].data);
        check({vecs[v].name, "_rd"},      x_result_rd_o, vecs[v].rd);
        check({vecs[v].name, "_we"},      x_result_we_o, vecs[v].wb);
        check({vecs[v].name, "_exc"},     {x_result_exc_o, x_result_exccode_o}, {vecs[v].exc, vecs[v].code});
        take_result();
        check({vecs[v].name, "_dropped"}, x_result_valid_o, 1'b0);
      end else begin
        commit(vecs[v].id, 1'b0);
        expect_no_result({vecs[v].name, "_no_result"}, 8);
      end
    end

    // Commit 1, kill 2, commit 3: results in order, id 2 never returned
    issue(mk_instr(7'd0, 3'b000, 5'd1, C0), 64'd1, 64'd1, 4'd1, acc, wb, rdy);
    issue(mk_instr(7'd0, 3'b000, 5'd2, C0), 64'd2, 64'd2, 4'd2, acc, wb, rdy);
    issue(mk_instr(7'd0, 3'b000, 5'd3, C0), 64'd3, 64'd3, 4'd3, acc, wb, rdy);
    commit(4'd1, 1'b0);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b0);
    wait_result(cyc);
    check("order_first_valid", x_result_valid_o, 1'b1);
    check("order_first_id",    x_result_id_o, 4'd1);
    check("order_first_data",  x_result_data_o, 64'd2);
    take_result();
    wait_result(cyc);
    check("order_second_valid", x_result_valid_o, 1'b1);
    check("order_second_id",    x_result_id_o, 4'd3);
    check("order_second_data",  x_result_data_o, 64'd6);
    take_result();
    expect_no_result("order_killed_absent", 10);

    // Fill the FIFO, then free one slot
    for (int k = 0; k < DEPTH; k++) begin
      issue(mk_instr(7'd0, 3'b000, 5'(k + 1), C0), 64'(k), 64'd100, 4'(k + 4), acc, wb, rdy);
      check("fill_ready", rdy, 1'b1);
    end
    check("full_ready_low", x_issue_ready_o, 1'b0);
    issue(mk_instr(7'd0, 3'b000, 5'd20, C0), 64'd9, 64'd9, 4'd8, acc, wb, rdy);
    check("full_reject_ready", rdy, 1'b0);
    commit(4'd4, 1'b0);
    wait_result(cyc);
    check("full_head_id", x_result_id_o, 4'd4);
    x_result_ready_i = 1'b1;
    #1;
    check("full_pop_cycle_ready", x_issue_ready_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    x_result_ready_i = 1'b0;
    check("after_pop_ready", x_issue_ready_o, 1'b1);
    for (int k = 1; k < DEPTH; k++) begin
      commit(4'(k + 4), 1'b0);
      wait_result(cyc);
      check("drain_id",   x_result_id_o, 4'(k + 4));
      check("drain_data", x_result_data_o, 64'(k + 100));
      take_result();
    end
    expect_no_result("drain_rejected_absent", 10);

    // Back-pressure: result held for 5 cycles
    issue(mk_instr(7'd0, 3'b001, 5'd1, C0), 64'd0, 64'd1, 4'd9, acc, wb, rdy);
    commit(4'd9, 1'b0);
    wait_result(cyc);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", x_result_valid_o, 1'b1);
      check("hold_data",  x_result_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("hold_id",    x_result_id_o, 4'd9);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    take_result();

    // Reset while the head is executing
    issue(mk_instr(7'd0, 3'b000, 5'd1, C0), 64'd4, 64'd4, 4'd10, acc, wb, rdy);
    commit(4'd10, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_valid", x_result_valid_o, 1'b0);
    check("midrst_ready", x_issue_ready_o, 1'b1);
    rst_i = 1'b0;
    expect_no_result("midrst_no_result", 10);

    // Same-cycle push and commit of the same id
    x_commit_valid_i = 1'b1;
    x_commit_id_i    = 4'd12;
    issue(mk_instr(7'd0, 3'b100, 5'd12, C0), 64'h10, 64'h01, 4'd12, acc, wb, rdy);
    x_commit_valid_i = 1'b0;
    wait_result(cyc);
    check("push_commit_valid", x_result_valid_o, 1'b1);
    check("push_commit_data",  x_result_data_o, 64'h11);
    take_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
